// File: rtl/miner_nonce_scheduler.sv
// Nonce range scheduler for NUM_CORES hash cores, plus a result collector that
// buffers difficulty-qualified hits through per-core pending slots and a FIFO.
module miner_nonce_scheduler #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     work_load,
  input  logic [31:0]              start_nonce,
  input  logic [31:0]              end_nonce,
  input  logic [7:0]               difficulty,
  output logic [31:0]              core_nonce,
  output logic                     core_nonce_valid,
  input  logic [NUM_CORES-1:0]     core_accept,
  input  logic [NUM_CORES-1:0]     core_hash_valid,
  input  logic [256*NUM_CORES-1:0] core_hash,
  input  logic [32*NUM_CORES-1:0]  core_result_nonce,
  output logic                     res_valid,
  output logic [31:0]              res_nonce,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     exhausted,
  output logic [15:0]              hit_count,
  output logic [15:0]              drop_count,
  output logic                     err_multi_accept
);

  localparam int unsigned NW    = 32;
  localparam int unsigned HW    = 256;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PW1   = PTR_W + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [NW-1:0] nonce_d, end_q, end_d;

  // Range walk: one nonce per accepting cycle, wrapping through zero.
  always_comb begin
    state_d = state;
    nonce_d = core_nonce;
    end_d   = end_q;
    if (work_load) begin
      state_d = RUN;
      nonce_d = start_nonce;
      end_d   = end_nonce;
    end else if (state == RUN && core_accept != '0) begin
      if (core_nonce == end_q) state_d = DONE;
      else                     nonce_d = core_nonce + NW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      core_nonce       <= '0;
      end_q            <= '0;
      core_nonce_valid <= 1'b0;
      busy             <= 1'b0;
      exhausted        <= 1'b0;
    end else begin
      state            <= state_d;
      core_nonce       <= nonce_d;
      end_q            <= end_d;
      core_nonce_valid <= (state_d == RUN);
      busy             <= (state_d == RUN);
      exhausted        <= (state_d == DONE);
    end
  end

  logic [NUM_CORES-1:0] pend_valid;
  logic [NW-1:0]        pend_nonce [NUM_CORES];
  logic [PTR_W-1:0]     rr_ptr;
  logic [NW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  logic [NUM_CORES-1:0] hit_c, drop_c;
  logic                 pop_c, can_write_c, grant_c;
  logic [PTR_W-1:0]     grant_idx_c;
  logic [PW1-1:0]       probe_c;
  logic [8:0]           shamt_c;
  logic [CW-1:0]        count_d, remain_c;
  logic [AW-1:0]        rd_next_c;
  logic [NW-1:0]        head_d;
  logic [4:0]           drop_n_c;
  logic [CNT_W:0]       drop_sum_c;

  // A hash qualifies when its top 'difficulty' bits are all zero.
  assign shamt_c = 9'd256 - {1'b0, difficulty};

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_CORES; i++)
      hit_c[i] = core_hash_valid[i] && (state != IDLE) && !work_load &&
                 ((core_hash[HW*i +: HW] >> shamt_c) == '0);
  end

  assign pop_c       = res_valid && res_ready && !work_load;
  assign can_write_c = (count != CW'(FIFO_DEPTH)) || pop_c;

  // Round-robin grant of one pending slot, searching upward from rr_ptr.
  always_comb begin
    grant_c     = 1'b0;
    grant_idx_c = '0;
    probe_c     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      probe_c = {1'b0, rr_ptr} + PW1'(k);
      if (probe_c >= PW1'(NUM_CORES)) probe_c = probe_c - PW1'(NUM_CORES);
      if (!grant_c && pend_valid[probe_c[PTR_W-1:0]]) begin
        grant_c     = 1'b1;
        grant_idx_c = probe_c[PTR_W-1:0];
      end
    end
    if (!can_write_c || work_load) grant_c = 1'b0;
  end

  always_comb begin
    drop_c   = '0;
    drop_n_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_c[i] = hit_c[i] && pend_valid[i] && !(grant_c && grant_idx_c == PTR_W'(i));
      drop_n_c  = drop_n_c + 5'(drop_c[i]);
    end
  end

  assign drop_sum_c = {1'b0, drop_count} + (CNT_W+1)'(drop_n_c);

  // Show-ahead head: next entry after a pop, or the bypassed write when empty.
  always_comb begin
    count_d   = count + CW'(grant_c) - CW'(pop_c);
    remain_c  = count - CW'(pop_c);
    rd_next_c = rd_ptr + AW'(pop_c);
    head_d    = res_nonce;
    if (remain_c != '0)  head_d = fifo_mem[rd_next_c];
    else if (grant_c)    head_d = pend_nonce[grant_idx_c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid       <= '0;
      rr_ptr           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      res_valid        <= 1'b0;
      res_nonce        <= '0;
      hit_count        <= '0;
      drop_count       <= '0;
      err_multi_accept <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++)  pend_nonce[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) fifo_mem[j]   <= '0;
    end else if (work_load) begin
      pend_valid       <= '0;
      rr_ptr           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      res_valid        <= 1'b0;
      res_nonce        <= '0;
      hit_count        <= '0;
      drop_count       <= '0;
      err_multi_accept <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (hit_c[i] && !drop_c[i]) begin
          pend_valid[i] <= 1'b1;
          pend_nonce[i] <= core_result_nonce[NW*i +: NW];
        end else if (grant_c && grant_idx_c == PTR_W'(i)) begin
          pend_valid[i] <= 1'b0;
        end
      end
      if (grant_c) begin
        fifo_mem[wr_ptr] <= pend_nonce[grant_idx_c];
        wr_ptr           <= wr_ptr + AW'(1);
        rr_ptr           <= (grant_idx_c == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx_c + PTR_W'(1);
        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count      <= count_d;
      res_valid  <= (count_d != '0);
      res_nonce  <= head_d;
      drop_count <= drop_sum_c[CNT_W] ? '1 : drop_sum_c[CNT_W-1:0];
      if ((core_accept & (core_accept - NUM_CORES'(1))) != '0) err_multi_accept <= 1'b1;
    end
  end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Scoreboard bench for miner_nonce_scheduler: a queue-based reference model
// predicts results and status; a negedge monitor compares whenever the DUT pops.
module tb_miner_nonce_scheduler;

  localparam int NC = 4;
  localparam int FD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              work_load;
  logic [31:0]       start_nonce, end_nonce;
  logic [7:0]        difficulty;
  logic [31:0]       core_nonce;
  logic              core_nonce_valid;
  logic [NC-1:0]     core_accept, core_hash_valid;
  logic [256*NC-1:0] core_hash;
  logic [32*NC-1:0]  core_result_nonce;
  logic              res_valid, res_ready;
  logic [31:0]       res_nonce;
  logic              busy, exhausted, err_multi_accept;
  logic [15:0]       hit_count, drop_count;

  always #5 clk = ~clk;

  miner_nonce_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .work_load(work_load),
    .start_nonce(start_nonce), .end_nonce(end_nonce), .difficulty(difficulty),
    .core_nonce(core_nonce), .core_nonce_valid(core_nonce_valid),
    .core_accept(core_accept), .core_hash_valid(core_hash_valid),
    .core_hash(core_hash), .core_result_nonce(core_result_nonce),
    .res_valid(res_valid), .res_nonce(res_nonce), .res_ready(res_ready),
    .busy(busy), .exhausted(exhausted), .hit_count(hit_count),
    .drop_count(drop_count), .err_multi_accept(err_multi_accept)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_run, m_done, m_err;
  logic [31:0] m_nonce, m_end;
  bit          m_pv [NC];
  logic [31:0] m_pn [NC];
  int          m_rr, m_occ, m_hits, m_drops;
  logic [31:0] sb_q [$];

  function automatic int lead_zeros(input logic [255:0] h);
    for (int b = 255; b >= 0; b--) if (h[b]) return 255 - b;
    return 256;
  endfunction

  task automatic m_clear();
    m_run = 0; m_done = 0; m_err = 0;
    m_nonce = '0; m_end = '0;
    m_rr = 0; m_occ = 0; m_hits = 0; m_drops = 0;
    sb_q.delete();
    for (int i = 0; i < NC; i++) begin m_pv[i] = 0; m_pn[i] = '0; end
  endtask

  task automatic m_step();
    bit hit [NC];
    bit pop;
    int g;
    pop = (m_occ > 0) && res_ready;
    g = -1;
    if (m_occ < FD || pop)
      for (int k = 0; k < NC; k++)
        if (g < 0 && m_pv[(m_rr + k) % NC]) g = (m_rr + k) % NC;
    for (int i = 0; i < NC; i++)
      hit[i] = (m_run || m_done) && core_hash_valid[i] &&
               (lead_zeros(core_hash[256*i +: 256]) >= int'(difficulty));
    if (g >= 0) begin
      sb_q.push_back(m_pn[g]);
      m_occ++;
      m_pv[g] = 0;
      m_rr = (g + 1) % NC;
      if (m_hits < 65535) m_hits++;
    end
    if (pop) m_occ--;
    for (int i = 0; i < NC; i++)
      if (hit[i]) begin
        if (m_pv[i]) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_pv[i] = 1;
          m_pn[i] = core_result_nonce[32*i +: 32];
        end
      end
    if ($countones(core_accept) > 1) m_err = 1;
    if (m_run && core_accept != '0) begin
      if (m_nonce == m_end) begin m_run = 0; m_done = 1; end
      else m_nonce = m_nonce + 32'd1;
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_clear();
      else if (work_load) begin
        m_clear();
        m_run   = 1;
        m_nonce = start_nonce;
        m_end   = end_nonce;
      end else m_step();
    end
  end

  // Monitor: status every cycle, result nonce on every DUT pop.
  initial begin
    forever begin
      @(negedge clk);
      check("core_nonce", core_nonce, m_nonce);
      check("core_nonce_valid", 32'(core_nonce_valid), 32'(m_run));
      check("busy", 32'(busy), 32'(m_run));
      check("exhausted", 32'(exhausted), 32'(m_done));
      check("res_valid", 32'(res_valid), 32'(m_occ > 0));
      check("hit_count", 32'(hit_count), m_hits);
      check("drop_count", 32'(drop_count), m_drops);
      check("err_multi_accept", 32'(err_multi_accept), 32'(m_err));
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL res_nonce: got 0x%08h, expected no result at %0t", res_nonce, $time);
        end else begin
          check("res_nonce", res_nonce, sb_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    work_load       = 1'b0;
    core_accept     = '0;
    core_hash_valid = '0;
  endtask

  function automatic logic [255:0] mk_hash(input int lz);
    logic [255:0] h;
    for (int w = 0; w < 8; w++) h[32*w +: 32] = $urandom;
    if (lz >= 256) return '0;
    h = h >> lz;
    h[255 - lz] = 1'b1;
    return h;
  endfunction

  task automatic set_hit(input int core, input int lz, input logic [31:0] n);
    core_hash_valid[core]          = 1'b1;
    core_hash[256*core +: 256]     = mk_hash(lz);
    core_result_nonce[32*core +: 32] = n;
  endtask

  task automatic load(input logic [31:0] s, input logic [31:0] e);
    start_nonce = s;
    end_nonce   = e;
    work_load   = 1'b1;
    tick();
    work_load   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    start_nonce = '0; end_nonce = '0; difficulty = '0;
    core_hash = '0; core_result_nonce = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Short range, single core accepting every cycle
    load(32'h10, 32'h13);
    core_accept = 4'b0001;
    repeat (5) tick();
    core_accept = '0;
    tick();

    // Range wrapping through zero
    load(32'hFFFF_FFFE, 32'h1);
    core_accept = 4'b0001;
    repeat (5) tick();
    core_accept = '0;

    // Difficulty boundary: 8 leading zeros hits, 7 does not
    difficulty = 8'd8;
    res_ready  = 1'b1;
    load(32'h0, 32'h100);
    set_hit(0, 8, 32'hA5A5_0001);
    tick();
    core_hash_valid = '0;
    repeat (3) tick();
    set_hit(0, 7, 32'hA5A5_0002);
    tick();
    core_hash_valid = '0;
    repeat (3) tick();

    // All cores hit together
    for (int c = 0; c < NC; c++) set_hit(c, 12, 32'hC000_0000 + 32'(c));
    tick();
    core_hash_valid = '0;
    repeat (6) tick();

    // Back-pressure: FIFO fills, one pending, one dropped; work_load clears
    res_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      set_hit(0, 9, 32'hD000_0000 + 32'(n));
      tick();
    end
    core_hash_valid = '0;
    repeat (3) tick();
    load(32'h200, 32'h300);
    repeat (2) tick();
    res_ready = 1'b1;

    // Multiple accepts in one cycle
    core_accept = 4'b0011;
    tick();
    core_accept = '0;
    repeat (2) tick();

    // Reset mid-operation, then a hit while idle
    set_hit(1, 20, 32'h0000_00EE);
    core_accept = 4'b0001;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_hit(2, 0, 32'h0000_0123);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 3) begin
        start_nonce = $urandom;
        end_nonce   = start_nonce + 32'($urandom_range(0, 40));
        difficulty  = 8'($urandom_range(0, 10));
        work_load   = 1'b1;
      end
      if ($urandom_range(0, 99) < 60)     core_accept = 4'(1) << $urandom_range(0, 3);
      else if ($urandom_range(0, 99) < 5) core_accept = 4'($urandom);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 99) < 25) set_hit(c, int'($urandom_range(0, 14)), $urandom);
      res_ready = ($urandom_range(0, 99) < 60);
      tick();
    end

    idle_inputs();
    res_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miner_nonce_scheduler.md
# miner_nonce_scheduler

Parametrised nonce scheduler and result collector for the double-SHA mining datapath. It drives a shared nonce bus to NUM_CORES hash cores over a bounded nonce range and qualifies each returned hash against a runtime difficulty. Every hit is buffered through per-core holding registers and a FIFO, so simultaneous hits are never silently lost. Qualified nonces are presented on a valid/ready port to the UART result transmitter.

## Interface
Parameters:
- NUM_CORES, 4, number of attached hash cores (1..16)
- FIFO_DEPTH, 8, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- work_load  in  1  one-cycle pulse: new work present; (re)start range
- start_nonce  in  32  first nonce of range, sampled on work_load
- end_nonce  in  32  last nonce of range (inclusive), sampled on work_load
- difficulty  in  8  required leading zero bits of hash (hash[255] is MSB); 0 = every hash hits
- core_nonce  out  32  nonce offered to cores
- core_nonce_valid  out  1  core_nonce is offerable
- core_accept  in  NUM_CORES  core i took core_nonce this cycle
- core_hash_valid  in  NUM_CORES  core i presents a finished hash
- core_hash  in  256*NUM_CORES  core i hash at [256*i +: 256]
- core_result_nonce  in  32*NUM_CORES  nonce of core i hash at [32*i +: 32]
- res_valid  out  1  res_nonce holds a qualified nonce
- res_nonce  out  32  FIFO head
- res_ready  in  1  consumer takes head when res_valid
- busy  out  1  state is RUN
- exhausted  out  1  whole range handed out (state DONE)
- hit_count  out  16  hits written to FIFO since work_load, saturating
- drop_count  out  16  hits lost since work_load, saturating
- err_multi_accept  out  1  sticky: >1 core_accept bit seen in one cycle

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- work_load in any state: next state RUN; core_nonce <= start_nonce, end latched; pending registers, FIFO, hit_count, drop_count, err_multi_accept cleared. Same-cycle hits and pops are discarded.
- RUN: core_nonce_valid=1. Any core_accept bit set -> core_nonce+1 (mod 2^32, wraps 0xFFFFFFFF->0). If accepted nonce == latched end -> DONE, core_nonce_valid=0, core_nonce holds end.
- More than one accept bit in a cycle: increment by 1 only, set err_multi_accept.
- start==end: exactly one nonce issued. end<start: range wraps through 0.
- Hit: core_hash_valid[i] && leading zeros of core_hash[i] >= difficulty, qualified in RUN or DONE only (IDLE ignores).
- Each core has a one-entry pending register. Hit with pending[i] empty (or being granted same edge) -> store nonce. Hit with pending[i] occupied and not granted -> drop, drop_count+1.
- Round-robin arbiter: each cycle, if FIFO not full, grants one occupied pending register, searching from rr_ptr upward. Granted entry goes to FIFO, hit_count+1. rr_ptr <= grantee+1 (mod NUM_CORES); rr_ptr=0 after reset and work_load.
- FIFO full: no grant, pendings hold. A pop and a write in the same cycle are both allowed when full.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: core_nonce=0, core_nonce_valid=0, res_valid=0, res_nonce=0, busy=0, exhausted=0, hit_count=0, drop_count=0, err_multi_accept=0.
- core_nonce updates on the edge after accept; the nonce bus is registered.
- Hit latency: hash valid sampled at edge t -> pending at t -> FIFO write at edge t+1 -> res_valid high in cycle after t+1, when uncontended and FIFO empty.
- FIFO is show-ahead: res_nonce valid whenever res_valid. Pop on edge with res_valid&&res_ready.
- busy/exhausted are registered and change on the same edge as the state.
- rst_n low mid-operation: all state cleared immediately; no partial output held.

## Test plan
- start=0x10, end=0x13, core 0 accepts every cycle -> core_nonce 0x10..0x13 then exhausted=1, core_nonce_valid=0 after the 4th accept.
- start=0xFFFFFFFE, end=0x1 -> issues FFFFFFFE, FFFFFFFF, 0, 1, then DONE.
- difficulty=8, hash top byte 0x00 -> res_nonce matches, res_valid 2 edges after sample; top byte 0x01 -> no hit, hit_count unchanged.
- NUM_CORES=4, all cores hit same cycle, res_ready=1 -> 4 results in order 0,1,2,3 on consecutive cycles, drop_count=0.
- res_ready=0, FIFO_DEPTH=8, core 0 hits 10 times -> 8 in FIFO, 1 pending, drop_count=1; work_load then clears res_valid and counters.
- core_accept=4'b0011 -> nonce +1 only, err_multi_accept=1 until next work_load or reset.
